// File: rtl/uart_cmd_master.sv
// Host-side command initiator: captures one command, serializes its frame to a
// UART transmitter, then assembles the response bytes from a UART receiver.
module uart_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TMO_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [3:0]               CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA,
  input  logic [DATA_WIDTH-1:0]    CMD_OP_A,
  input  logic [DATA_WIDTH-1:0]    CMD_OP_B,
  input  logic [3:0]               CMD_FUN,
  output logic [DATA_WIDTH-1:0]    TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_BUSY,
  input  logic [DATA_WIDTH-1:0]    RX_DATA,
  input  logic                     RX_VALID,
  output logic [ALU_OUT_WIDTH-1:0] RSP_DATA,
  output logic                     RSP_VALID,
  output logic                     RSP_TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_SEND_REQ, S_SEND_WAIT, S_RECV} state_t;

  localparam logic [1:0] CT_WR      = 2'b00;
  localparam logic [1:0] CT_RD      = 2'b01;
  localparam logic [1:0] CT_ALU     = 2'b10;
  localparam logic [1:0] CT_ALU_NOP = 2'b11;

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [1:0]            typ;
    logic [3:0]            addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [3:0]            fun;
  } cmd_t;

  // Byte idx of the frame for command c.
  function automatic logic [DATA_WIDTH-1:0] frame_byte(cmd_t c, logic [1:0] idx);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    case (c.typ)
      CT_WR: begin
        case (idx)
          2'd0:    b = DATA_WIDTH'(8'hAA);
          2'd1:    b = DATA_WIDTH'(c.addr);
          default: b = c.data;
        endcase
      end
      CT_RD:   b = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(c.addr);
      CT_ALU: begin
        case (idx)
          2'd0:    b = DATA_WIDTH'(8'hCC);
          2'd1:    b = c.op_a;
          2'd2:    b = c.op_b;
          default: b = DATA_WIDTH'(c.fun);
        endcase
      end
      default: b = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(c.fun);
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_idx(logic [1:0] typ);
    logic [1:0] n;
    case (typ)
      CT_WR:   n = 2'd2;
      CT_ALU:  n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  state_t                   state_q, state_d;
  cmd_t                     cmd_q, cmd_d, cmd_in;
  logic [1:0]               idx_q, idx_d;
  logic                     rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0]    rx_lo_q, rx_lo_d;
  logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;
  logic                     ready_q, ready_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic [ALU_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    cmd_in.typ  = CMD_TYPE;
    cmd_in.addr = CMD_ADDR;
    cmd_in.data = CMD_DATA;
    cmd_in.op_a = CMD_OP_A;
    cmd_in.op_b = CMD_OP_B;
    cmd_in.fun  = CMD_FUN;
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    idx_d         = idx_q;
    rcnt_d        = rcnt_q;
    rx_lo_d       = rx_lo_q;
    tmo_d         = tmo_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          cmd_d      = cmd_in;
          idx_d      = 2'd0;
          tx_data_d  = frame_byte(cmd_in, 2'd0);
          tx_valid_d = 1'b1;
          state_d    = S_SEND_REQ;
        end
      end
      S_SEND_REQ: begin
        if (TX_BUSY) begin
          tx_valid_d = 1'b0;
          state_d    = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        if (!TX_BUSY) begin
          if (idx_q != last_idx(cmd_q.typ)) begin
            idx_d      = idx_q + 2'd1;
            tx_data_d  = frame_byte(cmd_q, idx_q + 2'd1);
            tx_valid_d = 1'b1;
            state_d    = S_SEND_REQ;
          end else if (cmd_q.typ == CT_WR) begin
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            tmo_d   = '0;
            rcnt_d  = 1'b0;
            state_d = S_RECV;
          end
        end
      end
      default: begin
        // A byte arriving on the timeout cycle takes priority over the timeout.
        if (RX_VALID) begin
          tmo_d = '0;
          if (cmd_q.typ == CT_RD) begin
            rsp_data_d  = ALU_OUT_WIDTH'(RX_DATA);
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else if (rcnt_q) begin
            rsp_data_d  = ALU_OUT_WIDTH'({RX_DATA, rx_lo_q});
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rx_lo_d = RX_DATA;
            rcnt_d  = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      idx_q         <= '0;
      rcnt_q        <= 1'b0;
      rx_lo_q       <= '0;
      tmo_q         <= '0;
      ready_q       <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      idx_q         <= idx_d;
      rcnt_q        <= rcnt_d;
      rx_lo_q       <= rx_lo_d;
      tmo_q         <= tmo_d;
      ready_q       <= ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY   = ready_q;
  assign TX_VALID    = tx_valid_q;
  assign TX_DATA     = tx_data_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: a transmitter model checks frame bytes,
// a response monitor checks completion/timeout pulses against queued expectations.
module tb_uart_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR, CMD_FUN;
  logic [7:0]  CMD_DATA, CMD_OP_A, CMD_OP_B;
  logic [7:0]  TX_DATA, RX_DATA;
  logic        TX_VALID, TX_BUSY, RX_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID, RSP_TIMEOUT;

  always #5 CLK = ~CLK;

  uart_cmd_master #(
    .DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .TMO_WIDTH(16), .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_BUSY(TX_BUSY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  typedef struct {
    bit          tmo;
    logic [15:0] data;
    int          cyc;
  } rsp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] tx_exp[$];
  rsp_t       rsp_exp[$];
  int         mdl_phase = 0;
  int         mdl_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rsp(input bit tmo, input logic [15:0] d, input int c);
    rsp_t r;
    r.tmo  = tmo;
    r.data = d;
    r.cyc  = c;
    rsp_exp.push_back(r);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Transmitter: busy 2 cycles after a request, for 10 cycles.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST) begin
        TX_BUSY   = 1'b0;
        mdl_phase = 0;
      end else begin
        case (mdl_phase)
          0: if (TX_VALID && !TX_BUSY) begin
            if (tx_exp.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_unexpected: got byte %0h expected none", TX_DATA);
            end else begin
              chk("tx_byte", TX_DATA, tx_exp.pop_front());
            end
            mdl_cnt   = 2;
            mdl_phase = 1;
          end
          1: begin
            chk("tx_valid_hold", TX_VALID, 1);
            mdl_cnt--;
            if (mdl_cnt == 0) begin
              TX_BUSY   = 1'b1;
              mdl_cnt   = 10;
              mdl_phase = 2;
            end
          end
          default: begin
            chk("tx_valid_drop", TX_VALID, 0);
            mdl_cnt--;
            if (mdl_cnt == 0) begin
              TX_BUSY   = 1'b0;
              mdl_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RSP_VALID || RSP_TIMEOUT) begin
        if (RSP_VALID && RSP_TIMEOUT) begin
          checks++;
          errors++;
          $display("FAIL rsp_both: got valid and timeout together expected one");
        end
        chk("rsp_ready", CMD_READY, 1);
        if (rsp_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got valid=%0b timeout=%0b expected none", RSP_VALID, RSP_TIMEOUT);
        end else begin
          e = rsp_exp.pop_front();
          chk("rsp_kind", RSP_TIMEOUT, e.tmo);
          chk("rsp_data", RSP_DATA, e.data);
          if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_cmd_ready", CMD_READY, 1);
    chk("rst_tx_valid", TX_VALID, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_timeout", RSP_TIMEOUT, 0);
  endtask

  // Called at posedge+#3; returns at posedge+#3 one cycle after acceptance.
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    chk("cmd_ready_pre", CMD_READY, 1);
    CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d;
    CMD_OP_A = oa; CMD_OP_B = ob; CMD_FUN = f;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #3;
    CMD_VALID = 1'b0;
    CMD_TYPE = ~t; CMD_ADDR = ~a; CMD_DATA = ~d;
    CMD_OP_A = ~oa; CMD_OP_B = ~ob; CMD_FUN = ~f;
    chk("tx_valid_rise", TX_VALID, 1);
    chk("cmd_ready_busy", CMD_READY, 0);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while ((tx_exp.size() != 0 || mdl_phase != 0 || TX_BUSY) && n < 400) begin
      @(posedge CLK);
      #3;
      n++;
    end
    chk("tx_frame_timeout", (n >= 400), 0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_exp.size() != 0 && n < 100) begin
      @(posedge CLK);
      #3;
      n++;
    end
    chk("rsp_wait_timeout", (n >= 100), 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #3;
    RX_VALID = 1'b0;
    RX_DATA  = 8'hFF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_DATA = '0;
    CMD_OP_A = '0; CMD_OP_B = '0; CMD_FUN = '0; RX_DATA = '0; RX_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    check_reset_vals();
    RST = 1'b1;
    @(posedge CLK);
    #3;

    // RF write
    tx_exp.push_back(8'hAA); tx_exp.push_back(8'h05); tx_exp.push_back(8'h3C);
    issue(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    push_rsp(1'b0, 16'h0000, cyc + 1);
    wait_rsp();

    // RF read
    tx_exp.push_back(8'hBB); tx_exp.push_back(8'h02);
    issue(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    repeat (2) @(posedge CLK);
    #3;
    push_rsp(1'b0, 16'h0081, cyc + 1);
    rx_byte(8'h81);
    wait_rsp();

    // ALU with operands
    tx_exp.push_back(8'hCC); tx_exp.push_back(8'h0F);
    tx_exp.push_back(8'h03); tx_exp.push_back(8'h02);
    issue(2'b10, 4'h0, 8'h00, 8'h0F, 8'h03, 4'h2);
    wait_tx_done();
    repeat (2) @(posedge CLK);
    #3;
    push_rsp(1'b0, 16'h002D, cyc + 2);
    rx_byte(8'h2D);
    rx_byte(8'h00);
    wait_rsp();

    // Timeout after a single byte; RSP_DATA holds the previous result
    tx_exp.push_back(8'hDD); tx_exp.push_back(8'h00);
    issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    repeat (2) @(posedge CLK);
    #3;
    push_rsp(1'b1, 16'h002D, cyc + 1 + 20);
    rx_byte(8'h12);
    wait_rsp();
    chk("ready_after_tmo", CMD_READY, 1);

    // Final byte lands on the timeout cycle: byte wins
    tx_exp.push_back(8'hDD); tx_exp.push_back(8'h07);
    issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7);
    wait_tx_done();
    repeat (2) @(posedge CLK);
    #3;
    rx_byte(8'h34);
    repeat (19) @(posedge CLK);
    #3;
    push_rsp(1'b0, 16'h5634, cyc + 1);
    rx_byte(8'h56);
    wait_rsp();

    // Stray RX in IDLE, then CMD_VALID during SEND_WAIT
    rx_byte(8'hEE);
    repeat (3) @(posedge CLK);
    #3;
    chk("stray_rx_ready", CMD_READY, 1);
    tx_exp.push_back(8'hAA); tx_exp.push_back(8'h09); tx_exp.push_back(8'h5A);
    issue(2'b00, 4'h9, 8'h5A, 8'h00, 8'h00, 4'h0);
    begin
      int n = 0;
      while (!TX_BUSY && n < 50) begin
        @(posedge CLK);
        #3;
        n++;
      end
      chk("busy_wait_timeout", (n >= 50), 0);
    end
    @(posedge CLK);
    #3;
    CMD_TYPE = 2'b01; CMD_ADDR = 4'h3; CMD_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    #3;
    chk("busy_ignores_cmd", CMD_READY, 0);
    CMD_VALID = 1'b0;
    wait_tx_done();
    push_rsp(1'b0, 16'h0000, cyc + 1);
    wait_rsp();

    // Reset during the second byte of a CC frame
    tx_exp.push_back(8'hCC); tx_exp.push_back(8'h11);
    issue(2'b10, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
    begin
      int n = 0;
      while (tx_exp.size() != 0 && n < 100) begin
        @(posedge CLK);
        #3;
        n++;
      end
      chk("second_byte_timeout", (n >= 100), 0);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    @(posedge CLK);
    #3;
    tx_exp.push_back(8'hBB); tx_exp.push_back(8'h0E);
    issue(2'b01, 4'hE, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    repeat (2) @(posedge CLK);
    #3;
    push_rsp(1'b0, 16'h00A5, cyc + 1);
    rx_byte(8'hA5);
    wait_rsp();

    repeat (30) @(posedge CLK);
    #3;
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rsp_queue_drained", rsp_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Host-side command initiator for the UART register-file/ALU command protocol: accepts one command request, serializes it as a frame of bytes to a UART transmitter, then collects the response bytes from a UART receiver and returns the assembled result. It sits at the opposite end of the serial link from the system controller. It is used as the bench/host driver and as the master in board-to-board configurations. It runs entirely in the UART byte-clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width of frame bytes and operands.
- `ALU_OUT_WIDTH`, 16, width of the assembled ALU result.
- `TMO_WIDTH`, 16, width of the response timeout counter.
- `TIMEOUT_CYCLES`, 50000, number of idle cycles allowed while waiting for a response byte.

Ports:
- `CLK` in 1: single clock (UART byte-clock domain).
- `RST` in 1: asynchronous, active-low reset.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: block is idle and can accept a command.
- `CMD_TYPE` in 2: 00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands.
- `CMD_ADDR` in 4: register-file address.
- `CMD_DATA` in 8: register-file write data.
- `CMD_OP_A` in 8: ALU operand A.
- `CMD_OP_B` in 8: ALU operand B.
- `CMD_FUN` in 4: ALU function code.
- `TX_DATA` out 8: byte to transmit.
- `TX_VALID` out 1: byte request to the UART transmitter.
- `TX_BUSY` in 1: transmitter busy flag.
- `RX_DATA` in 8: received byte.
- `RX_VALID` in 1: one-cycle strobe, already synchronous to `CLK`.
- `RSP_DATA` out 16: response value.
- `RSP_VALID` out 1: one-cycle completion pulse.
- `RSP_TIMEOUT` out 1: one-cycle timeout pulse.

## Operation
- **Frames.** Bytes are sent in the order listed.
  - RF write: 0xAA, {4'h0,ADDR}, DATA. No response.
  - RF read: 0xBB, {4'h0,ADDR}. Expects 1 response byte.
  - ALU with operands: 0xCC, OP_A, OP_B, {4'h0,FUN}. Expects 2 response bytes, LSB first.
  - ALU without operands: 0xDD, {4'h0,FUN}. Expects 2 response bytes, LSB first.
- **Command capture.** A command is accepted when `CMD_VALID && CMD_READY`. All `CMD_*` fields are registered at acceptance; later input changes are ignored.
- **States.**
  - IDLE: `CMD_READY`=1. On accept, go to SEND_REQ with byte index 0.
  - SEND_REQ: drive `TX_VALID`=1 with `TX_DATA` stable. The first cycle with `TX_BUSY`=1 is acceptance; drop `TX_VALID` and go to SEND_WAIT.
  - SEND_WAIT: wait for `TX_BUSY`=0. If more bytes remain, increment the index and go to SEND_REQ. If this was the last byte: for RF write go to IDLE and pulse `RSP_VALID` with `RSP_DATA`=0; otherwise clear the timeout counter and the received-byte count, then go to RECV.
  - RECV:
    - On `RX_VALID`, store the byte (first byte to [7:0], second to [15:8]) and clear the timeout counter.
    - When the expected count is reached, go to IDLE and pulse `RSP_VALID`. For RF read, `RSP_DATA`={8'h00,byte}.
    - Otherwise the counter increments each cycle. When it reaches `TIMEOUT_CYCLES-1`, pulse `RSP_TIMEOUT` and go to IDLE; `RSP_DATA` keeps its previous value.
- **Boundary rules.**
  - `RX_VALID` outside RECV is ignored.
  - `RX_VALID` in the same cycle the timeout would fire: the byte wins and the counter clears.
  - `CMD_VALID` while busy is ignored; it is not queued.
  - `RSP_VALID` and `RSP_TIMEOUT` are never asserted in the same cycle.
  - `RST` low mid-frame aborts immediately to the reset state. No partial response pulse is produced.

## Timing
- **Reset values.** State IDLE, `CMD_READY`=1, `TX_VALID`=0, `TX_DATA`=0, `RSP_DATA`=0, `RSP_VALID`=0, `RSP_TIMEOUT`=0.
- `TX_VALID` rises the cycle after acceptance. `TX_DATA` is registered and valid in the same cycle as `TX_VALID`.
- `TX_VALID` falls the cycle after `TX_BUSY` is first sampled high.
- The next `TX_VALID` rises the cycle after `TX_BUSY` is sampled low in SEND_WAIT.
- `RSP_VALID` asserts the cycle after the final `RX_VALID` (RF read/ALU), or the cycle after the final `TX_BUSY` low (RF write).
- `CMD_READY` returns to 1 in the same cycle as `RSP_VALID`/`RSP_TIMEOUT`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **RF write.** ADDR=4'h5, DATA=8'h3C; transmitter model asserts busy 2 cycles after each request for 10 cycles -> `TX_DATA` sequence AA, 05, 3C. `RSP_VALID` pulses once with `RSP_DATA`=0.
- **RF read.** ADDR=4'h2; RX returns 8'h81 -> frame BB, 02; `RSP_DATA`=16'h0081; single `RSP_VALID` pulse the cycle after `RX_VALID`.
- **ALU with operands.** A=8'h0F, B=8'h03, FUN=4'h2; RX returns 2D then 00 -> frame CC, 0F, 03, 02; `RSP_DATA`=16'h002D.
- **Timeout.** `TIMEOUT_CYCLES`=20, ALU without operands, FUN=4'h0; only one RX byte 8'h12 arrives -> frame DD, 00; `RSP_TIMEOUT` pulses 20 cycles after that byte; `RSP_VALID` never pulses; `CMD_READY`=1 afterwards.
- **Stray and colliding inputs.** `RX_VALID` pulse in IDLE; `CMD_VALID` asserted during SEND_WAIT -> no state change and no second frame. `RX_VALID` coincident with the timeout cycle -> byte is accepted and no timeout pulse.
- **Reset mid-frame.** `RST` low during the second byte of a CC frame -> all outputs return to reset values immediately. After release, a new RF read completes normally.
